// File: rtl/fetch.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests,
// in-order response buffering and redirect flush feeding the decode stage.
module fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic [64:0] if_id_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0]   DEPTH_W  = FIFO_DEPTH[CW:0];
  localparam logic [CW-1:0] DEPTH_CW = FIFO_DEPTH[CW-1:0];
  localparam logic [IW-1:0] LAST_IDX = IW'(FIFO_DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   instr_mem_q [FIFO_DEPTH];

  logic [31:0] redirect_pc;
  logic [31:0] head_pc;
  logic [31:0] head_instr;
  logic [CW:0] credit;
  logic        head_valid;
  logic        out_valid;
  logic        pop;
  logic        push;
  logic        req_valid;
  logic        issue;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    redirect_pc = {redirect_pc_i[31:2], 2'b00};
    head_valid  = (count_q != '0);
    head_pc     = pc_mem_q[rd_ptr_q];
    head_instr  = instr_mem_q[rd_ptr_q];
    out_valid   = head_valid && !redirect_i;
    pop         = out_valid && !stall_i;
    // Slots already promised (in flight, including stale ones) plus buffered entries
    // must stay below the depth so every accepted response has a home.
    credit      = {1'b0, outstanding_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
    req_valid   = !rst_i && !redirect_i && (credit < DEPTH_W);
    issue       = req_valid && imem_req_ready_i;
    push        = imem_rsp_valid_i && !redirect_i && (drop_cnt_q == '0);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    last_pc_d     = head_valid ? head_pc : last_pc_q;
    outstanding_d = outstanding_q - CW'(imem_rsp_valid_i);
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      // Every response still owed after this cycle belongs to the old stream.
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid_i);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        outstanding_d = outstanding_q + CW'(1) - CW'(imem_rsp_valid_i);
      end
      if (imem_rsp_valid_i && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      last_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rsp_data_i;
    end
  end

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = fetch_pc_q;
  assign if_id_o          = {out_valid,
                             head_valid ? head_pc : last_pc_q,
                             head_valid ? head_instr : NOP};

  no_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                  !(push && (count_q == DEPTH_CW)));

endmodule
